// File: rtl/ascon_perm_ctrl_pkg.sv
// ascon_perm_ctrl_pkg
// Shared definitions for the ASCON permutation round sequencer:
//   - FSM state enum (IDLE, RUN, DONE)
//   - 4-bit round-index type and the first/last round constants
//   - mode encodings and the mode -> first-round decode
// Optional feature macro: ASCON_P8_EN (enables the 8-round p8 decode).
package ascon_perm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } perm_state_t;

  typedef logic [3:0] round_t;

  localparam round_t ROUND_FIRST_P12 = 4'd0;
  localparam round_t ROUND_FIRST_P6  = 4'd6;
  localparam round_t ROUND_FIRST_P8  = 4'd4;
  localparam round_t ROUND_LAST      = 4'd11;

  localparam logic [1:0] MODE_P12 = 2'b00;
  localparam logic [1:0] MODE_P6  = 2'b01;
  localparam logic [1:0] MODE_P8  = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  // All permutations end on round 11, so the round count is encoded purely
  // by where the counter starts. Reserved (and p8 when disabled) fall to p12.
  function automatic round_t first_round(input logic [1:0] mode);
    round_t r;
    r = ROUND_FIRST_P12;
    if (mode == MODE_P6) begin
      r = ROUND_FIRST_P6;
    end
`ifdef ASCON_P8_EN
    else if (mode == MODE_P8) begin
      r = ROUND_FIRST_P8;
    end
`endif
    return r;
  endfunction

endpackage

// File: rtl/ascon_round_counter.sv
// ascon_round_counter
// 4-bit loadable round counter that wraps to 0 after ROUND_LAST.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset (count -> 0)
//   clr      - synchronous clear, highest priority
//   load     - load load_val
//   load_val - first round index
//   en       - advance one round
//   count    - current round index
//   last     - count == ROUND_LAST
module ascon_round_counter
  import ascon_perm_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clr,
  input  logic   load,
  input  round_t load_val,
  input  logic   en,
  output round_t count,
  output logic   last
);

  assign last = (count == ROUND_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      // Wrap on the last round so the counter rests at 0 outside RUN.
      count <= last ? '0 : count + 4'd1;
    end
  end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// ascon_perm_ctrl
// Round sequencer for the ASCON permutation datapath. Runs p12, p6 or
// (with macro ASCON_P8_EN defined) p8, one round per clock, and reports
// completion to the mode FSM above it.
// Parameters:
//   DONE_STICKY - 0: done_o is a one-cycle pulse; 1: done_o holds until
//                 the next accepted start or reset
// Ports:
//   clock_i    - system clock, rising edge
//   resetb_i   - asynchronous active-low reset
//   start_i    - permutation request (accepted in IDLE or DONE)
//   mode_i     - 00 p12, 01 p6, 10 p8 (if enabled, else p12), 11 p12
//   round_o    - current round index for constant addition
//   sel_init_o - datapath mux takes the external state (first round only)
//   en_state_o - state-register load enable
//   busy_o     - permutation in progress
//   done_o     - result valid in the state register
// All outputs are decoded from registered state only (Moore).
module ascon_perm_ctrl
  import ascon_perm_ctrl_pkg::*;
#(
  parameter bit DONE_STICKY = 1'b0
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  output logic [3:0] round_o,
  output logic       sel_init_o,
  output logic       en_state_o,
  output logic       busy_o,
  output logic       done_o
);

  perm_state_t state;
  round_t      first_reg;
  round_t      count;
  logic        last;
  logic        accept;
  logic        illegal;

  assign accept  = start_i && (state != ST_RUN);
  // Counter beyond the last round cannot happen in normal operation; treat
  // it as corruption and bring everything back to a clean IDLE.
  assign illegal = (count > ROUND_LAST);

  ascon_round_counter u_counter (
    .clk      (clock_i),
    .rst_n    (resetb_i),
    .clr      (illegal),
    .load     (accept),
    .load_val (first_round(mode_i)),
    .en       (state == ST_RUN),
    .count    (count),
    .last     (last)
  );

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state     <= ST_IDLE;
      first_reg <= ROUND_FIRST_P12;
    end else if (illegal) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state     <= ST_RUN;
            first_reg <= first_round(mode_i);
          end
        end
        ST_RUN: begin
          if (last) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (start_i) begin
            state     <= ST_RUN;
            first_reg <= first_round(mode_i);
          end else if (!DONE_STICKY) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // first_reg remembers where this run started, so the initial-state select
  // is asserted exactly once per permutation.
  assign busy_o     = (state == ST_RUN);
  assign en_state_o = (state == ST_RUN);
  assign round_o    = (state == ST_RUN) ? count : 4'd0;
  assign sel_init_o = (state == ST_RUN) && (count == first_reg);
  assign done_o     = (state == ST_DONE);

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// tb_ascon_perm_ctrl
// Self-checking bench for ascon_perm_ctrl. Two instances (pulse and sticky
// done) share all inputs. The reference is a queue of per-cycle expected
// outputs: an accepted start enqueues one entry per round followed by a
// done entry; each clock consumes one entry. Honors macro ASCON_P8_EN.
module tb_ascon_perm_ctrl;

  typedef struct packed {
    logic [3:0] round;
    logic       sel;
    logic       en;
    logic       busy;
    logic       done;
  } rec_t;

  logic       clock_i = 1'b0;
  logic       resetb_i = 1'b0;
  logic       start_i = 1'b0;
  logic [1:0] mode_i = 2'b00;

  logic [3:0] round_p, round_s;
  logic       sel_p, sel_s, en_p, en_s, busy_p, busy_s, done_p, done_s;

  int n_checks = 0;
  int n_fail   = 0;

  rec_t exp_q[$];
  bit   held_done = 1'b0;

  always #5 clock_i = ~clock_i;

  ascon_perm_ctrl #(.DONE_STICKY(1'b0)) u_dut (
    .clock_i    (clock_i),
    .resetb_i   (resetb_i),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .round_o    (round_p),
    .sel_init_o (sel_p),
    .en_state_o (en_p),
    .busy_o     (busy_p),
    .done_o     (done_p)
  );

  ascon_perm_ctrl #(.DONE_STICKY(1'b1)) u_dut_s (
    .clock_i    (clock_i),
    .resetb_i   (resetb_i),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .round_o    (round_s),
    .sel_init_o (sel_s),
    .en_state_o (en_s),
    .busy_o     (busy_s),
    .done_o     (done_s)
  );

  function automatic int rounds_of(input logic [1:0] m);
    case (m)
      2'b01: return 6;
`ifdef ASCON_P8_EN
      2'b10: return 8;
`endif
      default: return 12;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: consumes one expected entry per clock.
  always @(posedge clock_i) begin
    rec_t r;
    rec_t popped;
    int   first;
    bit   busy_now;
    if (!resetb_i) begin
      exp_q.delete();
      held_done = 1'b0;
    end else begin
      busy_now = (exp_q.size() > 0) && exp_q[0].busy;
      if (start_i && !busy_now) begin
        exp_q.delete();
        held_done = 1'b0;
        first = 12 - rounds_of(mode_i);
        for (int i = first; i < 12; i++) begin
          r.round = i[3:0];
          r.sel   = (i == first);
          r.en    = 1'b1;
          r.busy  = 1'b1;
          r.done  = 1'b0;
          exp_q.push_back(r);
        end
        r = '0;
        r.done = 1'b1;
        exp_q.push_back(r);
      end else if (exp_q.size() > 0) begin
        popped = exp_q.pop_front();
        if (popped.done) held_done = 1'b1;
      end
    end
  end

  // Compare process: sampled 2 time units after each rising edge.
  always @(posedge clock_i) begin
    rec_t e0;
    rec_t e1;
    #2;
    if (resetb_i) begin
      if (exp_q.size() > 0) begin
        e0 = exp_q[0];
        e1 = exp_q[0];
      end else begin
        e0 = '0;
        e1 = '0;
        e1.done = held_done;
      end
      chk("pulse_round", int'(round_p), int'(e0.round));
      chk("pulse_sel",   int'(sel_p),   int'(e0.sel));
      chk("pulse_en",    int'(en_p),    int'(e0.en));
      chk("pulse_busy",  int'(busy_p),  int'(e0.busy));
      chk("pulse_done",  int'(done_p),  int'(e0.done));
      chk("sticky_round", int'(round_s), int'(e1.round));
      chk("sticky_sel",   int'(sel_s),   int'(e1.sel));
      chk("sticky_en",    int'(en_s),    int'(e1.en));
      chk("sticky_busy",  int'(busy_s),  int'(e1.busy));
      chk("sticky_done",  int'(done_s),  int'(e1.done));
    end
  end

  // Start a permutation and measure cycles until done_o (pulse instance).
  // Returns positioned 2 units after the edge where done_o was seen.
  task automatic run_measure(input logic [1:0] m, input int exp_lat,
                             input int exp_first);
    int lat;
    @(negedge clock_i);
    start_i = 1'b1;
    mode_i  = m;
    @(posedge clock_i);
    #2;
    chk("first_round", int'(round_p), exp_first);
    chk("first_sel", int'(sel_p), 1);
    @(negedge clock_i);
    start_i = 1'b0;
    lat = 1;
    while (done_p !== 1'b1 && lat < 40) begin
      @(posedge clock_i);
      #2;
      lat++;
    end
    chk("latency", lat, exp_lat);
  endtask

  initial begin
    int guard;
    repeat (2) @(negedge clock_i);
    chk("reset_round", int'(round_p), 0);
    chk("reset_busy", int'(busy_p), 0);
    resetb_i = 1'b1;

    // Idle for 20 cycles: model expects all zero.
    repeat (20) @(negedge clock_i);

    // p12 and p6 with literal latency/first-round expectations.
    run_measure(2'b00, 13, 0);
    run_measure(2'b01, 7, 6);

    // Back-to-back start in the DONE cycle (currently 2 units after edge).
    start_i = 1'b1;
    mode_i  = 2'b00;
    @(posedge clock_i);
    #2;
    chk("b2b_round", int'(round_p), 0);
    chk("b2b_sel", int'(sel_p), 1);
    chk("b2b_busy", int'(busy_p), 1);
    @(negedge clock_i);
    start_i = 1'b0;
    repeat (14) @(negedge clock_i);

`ifdef ASCON_P8_EN
    run_measure(2'b10, 9, 4);
`else
    run_measure(2'b10, 13, 0);
`endif
    run_measure(2'b11, 13, 0);

    // Sticky done holds through 10 idle cycles.
    repeat (10) @(negedge clock_i);
    chk("sticky_hold_lit", int'(done_s), 1);

    // Start held high with mode toggling during RUN.
    for (int i = 0; i < 30; i++) begin
      @(negedge clock_i);
      start_i = 1'b1;
      mode_i  = (i == 0) ? 2'b00 : 2'($urandom_range(0, 3));
    end
    @(negedge clock_i);
    start_i = 1'b0;
    repeat (16) @(negedge clock_i);

    // Asynchronous reset in the middle of a p12 run at round 5.
    @(negedge clock_i);
    start_i = 1'b1;
    mode_i  = 2'b00;
    @(negedge clock_i);
    start_i = 1'b0;
    guard = 0;
    while (round_p != 4'd5 && guard < 20) begin
      @(posedge clock_i);
      #2;
      guard++;
    end
    chk("reach_round5", int'(round_p), 5);
    #1;
    resetb_i = 1'b0;
    #1;
    chk("async_round", int'(round_p), 0);
    chk("async_busy", int'(busy_p), 0);
    chk("async_en", int'(en_p), 0);
    chk("async_sticky_busy", int'(busy_s), 0);
    @(negedge clock_i);
    @(negedge clock_i);
    resetb_i = 1'b1;
    repeat (3) @(negedge clock_i);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge clock_i);
      start_i = ($urandom_range(0, 3) == 0);
      mode_i  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) begin
        resetb_i = 1'b0;
        @(negedge clock_i);
        resetb_i = 1'b1;
      end
    end
    @(negedge clock_i);
    start_i = 1'b0;
    repeat (20) @(negedge clock_i);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
